// File: rtl/filter_mem_arbiter.sv
// Round-robin burst arbiter sharing one SRAM command port between the filter read (ch0) and write (ch1) streams.
// Optional FILTER_ARB_STATS_EN adds accept and stall counters.
module filter_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 4,
  parameter int BURST_LEN     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request0,
  input  logic                     command_entry0,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic [TAG_WIDTH-1:0]     tag0,
  output logic                     ready0,
  output logic                     valid0,
  output logic [DATA_WIDTH-1:0]    query0,
  output logic [TAG_WIDTH-1:0]     qtag0,
  input  logic                     request1,
  input  logic                     command_entry1,
  input  logic                     write_enable1,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0]    data_out1,
  output logic                     ready1,
  input  logic                     mem_ready,
  output logic                     mem_command_entry,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data,
  output logic [TAG_WIDTH-1:0]     mem_tag,
  input  logic                     mem_valid,
  input  logic [DATA_WIDTH-1:0]    mem_query,
  input  logic [TAG_WIDTH-1:0]     mem_qtag
`ifdef FILTER_ARB_STATS_EN
  ,
  output logic [31:0]              grant_count0,
  output logic [31:0]              grant_count1,
  output logic [31:0]              stall_count
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt, cnt_inc;
  logic              last_grant, last_grant_nxt;
  logic              accept0, accept1, burst_done;

  assign ready0  = (state == GRANT0) & mem_ready;
  assign ready1  = (state == GRANT1) & mem_ready;
  assign accept0 = command_entry0 & ready0;
  assign accept1 = command_entry1 & ready1;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = '0;
    cnt_inc        = burst_cnt;
    // count saturates at BURST_LEN so a lone channel keeps streaming
    if ((accept0 | accept1) && (burst_cnt != CNT_W'(BURST_LEN)))
      cnt_inc = burst_cnt + 1'b1;
    burst_done = (cnt_inc == CNT_W'(BURST_LEN));
    case (state)
      IDLE: begin
        if (request0 && (!request1 || last_grant)) state_nxt = GRANT0;
        else if (request1)                         state_nxt = GRANT1;
      end
      GRANT0: begin
        if (request1 && (burst_done || !request0)) state_nxt = TURN;
        else if (!request0)                        state_nxt = IDLE;
      end
      GRANT1: begin
        if (request0 && (burst_done || !request1)) state_nxt = TURN;
        else if (!request1)                        state_nxt = IDLE;
      end
      TURN:    state_nxt = last_grant ? GRANT0 : GRANT1;
      default: state_nxt = IDLE;
    endcase
    if ((state_nxt == state) && ((state == GRANT0) || (state == GRANT1)))
      burst_cnt_nxt = cnt_inc;
    if ((state_nxt == GRANT0) && (state != GRANT0)) last_grant_nxt = 1'b0;
    if ((state_nxt == GRANT1) && (state != GRANT1)) last_grant_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Command register: fields hold between accepts; ch0 has no data, ch1 has no tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_command_entry <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_address       <= '0;
      mem_data          <= '0;
      mem_tag           <= '0;
    end else begin
      mem_command_entry <= accept0 | accept1;
      if (accept1) begin
        mem_write_enable <= write_enable1;
        mem_address      <= address1;
        mem_data         <= data_out1;
        mem_tag          <= '0;
      end else if (accept0) begin
        mem_write_enable <= 1'b0;
        mem_address      <= address0;
        mem_data         <= '0;
        mem_tag          <= tag0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid0 <= 1'b0;
      query0 <= '0;
      qtag0  <= '0;
    end else begin
      valid0 <= mem_valid;
      query0 <= mem_query;
      qtag0  <= mem_qtag;
    end
  end

`ifdef FILTER_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count0 <= '0;
      grant_count1 <= '0;
      stall_count  <= '0;
    end else begin
      if (accept0) grant_count0 <= grant_count0 + 32'd1;
      if (accept1) grant_count1 <= grant_count1 + 32'd1;
      if ((request0 && !ready0) || (request1 && !ready1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/filter_mem_arbiter.md
Name: filter_mem_arbiter

Overview:
- Shares one SRAM command port between the filter's two memory channels: channel 0 (pixel read stream) and channel 1 (result write stream).
- Sits between the filter and the SRAM controller.
- Grants the port in bounded bursts, round-robin between the channels, with a one-cycle turnaround on every channel switch.
- Forwards commands to memory with one register stage and returns read data to channel 0.

Parameters:
- ADDRESS_WIDTH, 32, address width on both channels and on the memory side
- DATA_WIDTH, 32, data word width
- TAG_WIDTH, 4, read tag width
- BURST_LEN, 8, maximum consecutive accepted commands per grant while the other channel is requesting (>=1)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- request0  in  1  channel 0 wants the port
- command_entry0  in  1  channel 0 read command valid
- address0  in  ADDRESS_WIDTH  channel 0 read address
- tag0  in  TAG_WIDTH  channel 0 read tag
- ready0  out  1  channel 0 command accepted this cycle if command_entry0 is high
- valid0  out  1  read return valid
- query0  out  DATA_WIDTH  read return data
- qtag0  out  TAG_WIDTH  read return tag
- request1  in  1  channel 1 wants the port
- command_entry1  in  1  channel 1 command valid
- write_enable1  in  1  channel 1 command is a write
- address1  in  ADDRESS_WIDTH  channel 1 address
- data_out1  in  DATA_WIDTH  channel 1 write data
- ready1  out  1  channel 1 accept strobe
- mem_ready  in  1  memory can accept a command this cycle
- mem_command_entry  out  1  command to memory
- mem_write_enable  out  1  command to memory is a write
- mem_address  out  ADDRESS_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_tag  out  TAG_WIDTH  memory read tag
- mem_valid  in  1  memory read return valid
- mem_query  in  DATA_WIDTH  memory read return data
- mem_qtag  in  TAG_WIDTH  memory read return tag

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, burst count 0, last_grant = 1 (so channel 0 wins the first tie).
- FSM states: IDLE, GRANT0, GRANT1, TURN.
- IDLE:
  - Only request0 -> GRANT0; only request1 -> GRANT1.
  - Both -> the channel that is not last_grant.
- GRANTn:
  - readyn = (state==GRANTn) & mem_ready, combinational. Ready is never high outside GRANTn.
  - Accept = command_entryn & readyn. command_entry while ready is low is ignored, not queued.
  - Each accept increments the burst count.
  - Exit to TURN when either:
    - an accept brings the count to BURST_LEN and the other request is high; or
    - requestn is low and the other request is high.
  - requestn low and other request low -> IDLE.
  - last_grant is set to n on entry.
- TURN: exactly one cycle, both readys low. Burst count cleared. Next state is GRANT of the other channel (the one not last_grant).
- At BURST_LEN with the other channel idle: count saturates, the grant is held, no switch.
- Command path, 1-cycle latency: on accept, the next cycle drives mem_command_entry=1 plus the registered address, data and tag. mem_write_enable = write_enable1 for channel 1, 0 for channel 0. With no accept, mem_command_entry=0 and the other mem_* fields hold their last values.
- Read return, 1-cycle latency: valid0 <= mem_valid, query0 <= mem_query, qtag0 <= mem_qtag. Applies regardless of grant state.
- Simultaneous new request and burst completion: the switch takes priority over an IDLE pass.
- Reset mid-burst: the pending registered command is dropped (mem_command_entry=0 the next cycle). mem_valid arriving while reset is high is dropped.

Optional Feature:
- Macro: FILTER_ARB_STATS_EN.
- Enabled: adds outputs grant_count0 and grant_count1 (32 bits each). Each counts accepted commands for its channel, wraps at 2^32, and is cleared by reset.
- Also adds stall_count (32 bits), incremented every cycle that any requestn is high while readyn is low.
- Disabled: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset priority: after reset, request0=request1=1 held, both issue command_entry every cycle, mem_ready=1 -> channel 0 gets 8 accepts, 1 TURN cycle, channel 1 gets 8 accepts, repeating. mem_command_entry pattern: 8 high, 1 low.
- Solo stream: only channel 0 requesting, 20 reads at addresses 0..19 with tags 1 -> 20 consecutive accepts with no TURN. mem_address 0..19 appears one cycle after each accept, mem_write_enable=0.
- Backpressure: mem_ready low for 3 cycles mid-burst -> ready0 low for those 3 cycles, no mem_command_entry, burst count unchanged; the burst resumes afterwards.
- Early release: request1 drops after 3 writes while request0 is high -> one TURN cycle, then GRANT0. The 3 writes appear with mem_write_enable=1 and correct data.
- Read return: mem_valid=1 with mem_query=32'hDEADBEEF, mem_qtag=1 -> next cycle valid0=1, query0=32'hDEADBEEF, qtag0=1, irrespective of the current grant.
- Reset mid-burst: assert reset in the cycle of an accept -> mem_command_entry stays 0 the next cycle, state IDLE, all outputs 0.
